// File: rtl/softmax_exp_sequencer_if.sv
// softmax_exp_sequencer_if: bundles the score stream, exp-unit operand/result and row-result signals
interface softmax_exp_sequencer_if #(
   parameter int BIT_WIDTH = 16,
   parameter int LEN_WIDTH = 7,
   parameter int SUM_WIDTH = 24
);
   logic                 i_start;
   logic [LEN_WIDTH-1:0] i_len;
   logic                 o_ready;
   logic                 i_valid;
   logic [BIT_WIDTH-1:0] i_data;
   logic                 o_in_ready;
   logic                 o_exp_valid;
   logic [BIT_WIDTH-1:0] o_exp_data;
   logic                 i_exp_valid;
   logic [BIT_WIDTH-1:0] i_exp;
   logic                 o_valid;
   logic [BIT_WIDTH-1:0] o_data;
   logic                 o_last;
   logic [SUM_WIDTH-1:0] o_sum;
   logic                 o_done;
   logic                 o_err;
   modport master (
      output i_start, i_len, i_valid, i_data, i_exp_valid, i_exp,
      input  o_ready, o_in_ready, o_exp_valid, o_exp_data, o_valid, o_data, o_last, o_sum, o_done, o_err
   );
   modport slave (
      input  i_start, i_len, i_valid, i_data, i_exp_valid, i_exp,
      output o_ready, o_in_ready, o_exp_valid, o_exp_data, o_valid, o_data, o_last, o_sum, o_done, o_err
   );
endinterface

// File: rtl/softmax_exp_sequencer.sv
// softmax_exp_sequencer: buffers a Q4.12 score row, issues (x - max) to the exp unit and sums its results; SOFTMAX_TIMEOUT_EN adds a return watchdog
module softmax_exp_sequencer #(
   parameter int BIT_WIDTH      = 16,
   parameter int MAX_LEN        = 64,
   parameter int LEN_WIDTH      = 7,
   parameter int SUM_WIDTH      = 24,
   parameter int TIMEOUT_CYCLES = 32
) (
   input logic i_clk,
   input logic i_rst,
   softmax_exp_sequencer_if.slave bus
);
   localparam int AW = $clog2(MAX_LEN);
   localparam logic [LEN_WIDTH-1:0] ONE = 1;
   localparam logic [BIT_WIDTH-1:0] MOST_NEG = {1'b1, {(BIT_WIDTH-1){1'b0}}};

   if (MAX_LEN >= 2 ** LEN_WIDTH || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("softmax_exp_sequencer: LEN_WIDTH must hold MAX_LEN and TIMEOUT_CYCLES must be positive");
   end

   typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, DONE} state_t;

   state_t                        state;
   logic [BIT_WIDTH-1:0]          buffer [MAX_LEN];
   logic [LEN_WIDTH-1:0]          len, ld, is, rt;
   logic signed [BIT_WIDTH-1:0]   row_max;
   logic [BIT_WIDTH:0]            diff;
   logic [BIT_WIDTH-1:0]          operand;
   logic [SUM_WIDTH:0]            sum_next;
   logic                          bad_len;
   logic                          accept_ret;
`ifdef SOFTMAX_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_ONE = 1;
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0] wd;
`endif

   // operand subtraction at one extra bit with saturation, sum update and start/return qualifiers
   always_comb begin
      diff       = {buffer[is[AW-1:0]][BIT_WIDTH-1], buffer[is[AW-1:0]]} - {row_max[BIT_WIDTH-1], row_max};
      operand    = diff[BIT_WIDTH] != diff[BIT_WIDTH-1] ? MOST_NEG : diff[BIT_WIDTH-1:0];
      sum_next   = {1'b0, bus.o_sum} + {{(SUM_WIDTH+1-BIT_WIDTH){1'b0}}, bus.i_exp};
      bad_len    = bus.i_len == '0 || bus.i_len > LEN_WIDTH'(MAX_LEN);
      accept_ret = bus.i_exp_valid && (state == ISSUE || state == DRAIN) && rt != len;
   end

   // row buffer; contents after reset are irrelevant so it carries no reset
   always_ff @(posedge i_clk) begin
      if (state == LOAD && bus.i_valid) buffer[ld[AW-1:0]] <= bus.i_data;
   end

   // row sequencer with registered outputs; pulse outputs default low every cycle
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state            <= IDLE;
         len              <= '0;
         ld               <= '0;
         is               <= '0;
         rt               <= '0;
         row_max          <= '0;
         bus.o_ready      <= 1'b1;
         bus.o_in_ready   <= 1'b0;
         bus.o_exp_valid  <= 1'b0;
         bus.o_exp_data   <= '0;
         bus.o_valid      <= 1'b0;
         bus.o_data       <= '0;
         bus.o_last       <= 1'b0;
         bus.o_sum        <= '0;
         bus.o_done       <= 1'b0;
         bus.o_err        <= 1'b0;
`ifdef SOFTMAX_TIMEOUT_EN
         wd               <= '0;
`endif
      end else begin
         bus.o_exp_valid <= 1'b0;
         bus.o_valid     <= 1'b0;
         bus.o_last      <= 1'b0;
         bus.o_done      <= 1'b0;
         bus.o_err       <= 1'b0;
         if (accept_ret) begin
            bus.o_valid <= 1'b1;
            bus.o_data  <= bus.i_exp;
            bus.o_last  <= rt == len - ONE;
            bus.o_sum   <= sum_next[SUM_WIDTH] ? '1 : sum_next[SUM_WIDTH-1:0];
            rt          <= rt + ONE;
         end
         case (state)
            IDLE: if (bus.i_start) begin
               if (bad_len) bus.o_err <= 1'b1;
               else begin
                  len            <= bus.i_len;
                  row_max        <= MOST_NEG;
                  ld             <= '0;
                  is             <= '0;
                  rt             <= '0;
                  bus.o_sum      <= '0;
                  bus.o_ready    <= 1'b0;
                  bus.o_in_ready <= 1'b1;
                  state          <= LOAD;
               end
            end
            LOAD: if (bus.i_valid) begin
               ld <= ld + ONE;
               if ($signed(bus.i_data) > row_max) row_max <= bus.i_data;
               if (ld == len - ONE) begin
                  bus.o_in_ready <= 1'b0;
                  state          <= ISSUE;
               end
            end
            ISSUE: begin
               bus.o_exp_valid <= 1'b1;
               bus.o_exp_data  <= operand;
               is              <= is + ONE;
               if (is == len - ONE) state <= DRAIN;
            end
            DRAIN: if (rt == len) begin
               bus.o_done <= 1'b1;
               state      <= DONE;
            end
            DONE: begin
               bus.o_ready <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
`ifdef SOFTMAX_TIMEOUT_EN
         if ((state == ISSUE || state == DRAIN) && !bus.i_exp_valid) begin
            wd <= wd + WD_ONE;
            if (wd == WD_LIMIT) begin
               state           <= IDLE;
               bus.o_ready     <= 1'b1;
               bus.o_err       <= 1'b1;
               bus.o_done      <= 1'b0;
               bus.o_exp_valid <= 1'b0;
               wd              <= '0;
            end
         end else wd <= '0;
`endif
      end
   end
endmodule

// File: doc/softmax_exp_sequencer.md
Name: softmax_exp_sequencer

Overview:
- Row-level controller that sequences the shared Q4.12 exponent pipeline for softmax.
- Buffers one row of up to MAX_LEN signed Q4.12 scores and finds the row maximum.
- Issues (x - max) operands to the exp unit, then collects its results, forwards them downstream and accumulates the row sum for the later normaliser.
- Sits between the attention-score stream and the exp unit; the exp unit itself is external.

Parameters:
BIT_WIDTH, 16, data width (Q4.12)
MAX_LEN, 64, maximum row length / buffer depth
LEN_WIDTH, 7, width of length and counter fields (must hold MAX_LEN)
SUM_WIDTH, 24, exp-sum accumulator width
TIMEOUT_CYCLES, 32, watchdog limit (used only with SOFTMAX_TIMEOUT_EN)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_start  in  1  start pulse for a row; sampled only in IDLE
i_len  in  LEN_WIDTH  row length, sampled with i_start
o_ready  out  1  high in IDLE
i_valid  in  1  score valid
i_data  in  BIT_WIDTH  signed Q4.12 score
o_in_ready  out  1  high in LOAD
o_exp_valid  out  1  operand valid to exp unit (registered)
o_exp_data  out  BIT_WIDTH  operand x - max, signed Q4.12 (registered)
i_exp_valid  in  1  result valid from exp unit
i_exp  in  BIT_WIDTH  exp result, Q4.12, non-negative
o_valid  out  1  forwarded exp result valid
o_data  out  BIT_WIDTH  forwarded exp result
o_last  out  1  with o_valid on the len-th result
o_sum  out  SUM_WIDTH  accumulated sum; held until next i_start
o_done  out  1  one-cycle pulse at row completion
o_err  out  1  one-cycle pulse on a rejected start or a timeout

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst is synchronous and active-high.
- Reset, including mid-row: state goes to IDLE and all counters and max are cleared.
  - Every output is 0, except o_ready = 1.
  - Buffer contents are don't-care.
- IDLE:
  - i_start with 1 <= i_len <= MAX_LEN: latch len, max = -32768, load/issue/return counters = 0, o_sum = 0, go to LOAD.
  - i_start with i_len = 0 or i_len > MAX_LEN: o_err pulse next cycle, stay in IDLE.
- LOAD:
  - Each cycle with i_valid: buf[ld] = i_data; max = signed max(max, i_data); ld++.
  - Accepting the len-th sample: go to ISSUE next cycle.
- ISSUE: one operand per cycle, no backpressure.
  - o_exp_data = sat16(buf[is] - max), computed at BIT_WIDTH+1 bits. The difference is always <= 0; values below -32768 saturate to 0x8000.
  - o_exp_valid is registered and first asserts the cycle after entering ISSUE.
  - After the len-th operand: go to DRAIN.
- Result return (ISSUE or DRAIN state):
  - On i_exp_valid: o_valid = 1 and o_data = i_exp (registered, 1-cycle latency); sum += i_exp zero-extended, saturating at all-ones; rt++.
  - o_last asserts when rt == len-1.
  - Returns beyond len, and any returns in IDLE or LOAD, are ignored.
- DRAIN: when rt reaches len (including when it completes during ISSUE), go to DONE.
- DONE: o_done pulses for one cycle with the final o_sum valid, then IDLE.
- Ignored inputs: i_start outside IDLE and i_valid outside LOAD.
- Exp-unit latency: the controller does not depend on it; it only counts returns (the current unit has a 3-cycle latency).

Optional Feature:
SOFTMAX_TIMEOUT_EN
- Defined: a watchdog counts consecutive cycles in ISSUE/DRAIN with no i_exp_valid.
  - Reaching TIMEOUT_CYCLES aborts the row: o_err pulse, no o_done, return to IDLE.
  - The counter resets on each i_exp_valid.
- Undefined: no watchdog logic; the controller waits indefinitely in DRAIN.

Test Plan:
- Max and operands: len=4, data {0x0000, 0xF000, 0x1000, 0x0800} -> operands {0xF000, 0xE000, 0x0000, 0xF800}, in order on consecutive cycles.
- Operand saturation: len=2, data {0x7000, 0x9000} -> operands {0x0000, 0x8000}.
- Full row: len=64, stub exp unit returning 0x1000 with 3-cycle latency -> 64 o_valid beats, o_last on the 64th, o_sum = 0x040000, single o_done.
- Rejected start: i_len=0, then i_len=65 -> o_err each time, o_ready stays 1, no o_in_ready.
- Reset mid-row: i_rst during ISSUE of a len=8 row -> next cycle o_ready=1, o_exp_valid=0; a new len=1 row with data 0x0400 gives operand 0x0000.
- Watchdog (macro defined): stub returns 2 of 4 results, then stalls -> o_err exactly TIMEOUT_CYCLES cycles after the last return, no o_done, IDLE.
